mips_decode_execute: RTL and testbench
======================================

# mips_decode_execute

Single-cycle MIPS decode/execute block: combines the main control unit, the ALU-control decoder and the 32-bit ALU behind one registered output stage. It sits between the instruction parser/register file and the data memory/PC-update logic of the core. It consumes parsed instruction fields plus register read data, and produces datapath control strobes, ALU result, compare flags and the branch condition one clock later.

## Interface
- No parameters.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  fields below are a real instruction this cycle.
- opcode  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- shamt  in  5  instr[10:6].
- imm  in  16  instr[15:0].
- rs_data  in  32  register rs read data (operand A).
- rt_data  in  32  register rt read data.
- reg_write, reg_dst, mem_read, mem_write, mem_to_reg, branch, jump, alu_src  out  1 each  registered control strobes.
- alu_op  out  3  registered ALU operation code.
- result  out  32  registered ALU result.
- zero, lt, gt  out  1 each  registered flags: result==0, signed A<B, signed A>B.
- b_cond  out  1  registered branch-taken condition.
- illegal  out  1  registered unsupported opcode/funct flag.

## Operation
- alu_op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 NOR, 6 SLL, 7 SRL.
- R-type (opcode 000000) by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL. Strobes: reg_write=1, reg_dst=1, alu_src=0.
- I-type: addi 001000 ADD, slti 001010 SLT, andi 001100 AND, ori 001101 OR; reg_write=1, reg_dst=0, alu_src=1.
- lw 100011: ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1. sw 101011: ADD, alu_src=1, mem_write=1.
- beq 000100 / bne 000101: SUB, alu_src=0, branch=1. b_cond = zero (beq) or !zero (bne); b_cond=0 for all other opcodes.
- j 000010: jump=1, all other strobes 0, alu_op ADD.
- Immediate: sign-extended for addi, slti, lw, sw; zero-extended for andi, ori.
- Operand B = alu_src ? extended imm : rt_data. SLL/SRL: result = rt_data shifted by shamt (logical), rs_data ignored.
- ADD/SUB wrap modulo 2^32; no overflow exception. SLT: result = {31'b0, signed(A)<signed(B)}.
- lt/gt: signed compare of operand A vs operand B, for every op.
- Unsupported opcode or R-type funct: illegal=1, every strobe 0, alu_op ADD, result still computed.

## Timing
- All outputs update on rising clk; decode and ALU are combinational from inputs, registered once: latency 1 cycle, throughput 1 per cycle.
- rst=1 at the edge: every output 0 (result 0, zero 0), overriding instr_valid.
- instr_valid=0 at the edge: reg_write, mem_read, mem_write, branch, jump, b_cond, illegal register 0 (bubble); result, alu_op, flags, reg_dst, mem_to_reg, alu_src hold.
- Reset deasserted mid-stream: first valid instruction after reset appears on outputs the following edge.

## Configuration
- MIPS_DECODE_SHIFT_EN: defined -> SLL/SRL funct codes decoded as above. Undefined -> funct 000000/000010 are unsupported (illegal=1, no reg_write) and the ALU contains no shifter; alu_op 6/7 are never produced.

## Structure
- Package mips_decode_pkg: opcode and funct localparams, alu_op enum typedef, control-bundle struct typedef.
- One sub-module: mips_decode_alu (purely combinational 32-bit ALU: A, B, shamt, alu_op -> result, zero, lt, gt). Decoders and output register live in the top.

## Test plan
- add: rs=5, rt=7, funct 100000, valid -> next cycle result=12, reg_write=1, reg_dst=1, zero=0, lt=1.
- addi sign-extend: rs=1, imm=0xFFFF -> result=0, zero=1, alu_src=1; andi imm=0xFFFF, rs=0xFFFFFFFF -> result=0x0000FFFF.
- beq rs=rt=9 -> branch=1, zero=1, b_cond=1; bne same operands -> b_cond=0; bne rs=9, rt=3 -> b_cond=1, gt=1.
- lw rs=0x100, imm=0xFFFC -> result=0xFC, mem_read=1, mem_to_reg=1; sw -> mem_write=1, reg_write=0.
- sll rt=1, shamt=31 -> result=0x80000000 (with MIPS_DECODE_SHIFT_EN); without macro -> illegal=1, reg_write=0.
- rst asserted mid-stream -> all outputs 0 next edge; valid dropped after add -> reg_write=0, result holds 12; opcode 111111 -> illegal=1.

Source files
------------

// File: rtl/mips_decode_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcode/funct values,
// ALU operation codes and the registered control bundle.
package mips_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    logic    alu_src;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_decode_alu.sv
// Combinational 32-bit ALU with signed compare flags.
// MIPS_DECODE_SHIFT_EN adds the logical shifter (SLL/SRL on B by shamt).
module mips_decode_alu
  import mips_decode_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt,
  output logic        gt
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;

`ifndef MIPS_DECODE_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  always_comb begin
    result = a + b;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, (a_s < b_s)};
      ALU_NOR: result = ~(a | b);
`ifdef MIPS_DECODE_SHIFT_EN
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
`endif
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);
  assign lt   = (a_s < b_s);
  assign gt   = (a_s > b_s);

endmodule

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode/execute: main control + ALU control + ALU, one output register.
// Optional MIPS_DECODE_SHIFT_EN enables SLL/SRL decoding and the ALU shifter.
module mips_decode_execute
  import mips_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic [31:0] result,
  output logic        zero,
  output logic        lt,
  output logic        gt,
  output logic        b_cond,
  output logic        illegal
);

  ctrl_t       ctrl;
  logic        sign_ext;
  logic [31:0] imm_ext;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_gt;
  logic        b_cond_c;

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    sign_ext    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
`ifdef MIPS_DECODE_SHIFT_EN
          FN_SLL:  ctrl.alu_op = ALU_SLL;
          FN_SRL:  ctrl.alu_op = ALU_SRL;
`endif
          default: begin
            ctrl         = '0;
            ctrl.alu_op  = ALU_ADD;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        sign_ext       = 1'b1;
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
        sign_ext       = 1'b1;
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        sign_ext        = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        sign_ext       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

  assign imm_ext = sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  assign op_b    = ctrl.alu_src ? imm_ext : rt_data;

  mips_decode_alu u_alu (
    .a      (rs_data),
    .b      (op_b),
    .shamt  (shamt),
    .alu_op (ctrl.alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .lt     (alu_lt),
    .gt     (alu_gt)
  );

  // branch is only decoded for beq/bne, so the opcode test picks the polarity
  assign b_cond_c = ctrl.branch & ((opcode == OP_BEQ) ? alu_zero : ~alu_zero);

  // ---- output register (p1) ----
  ctrl_t       ctrl_p1;
  logic [31:0] result_p1;
  logic        zero_p1;
  logic        lt_p1;
  logic        gt_p1;
  logic        b_cond_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p1   <= '0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      lt_p1     <= 1'b0;
      gt_p1     <= 1'b0;
      b_cond_p1 <= 1'b0;
    end else if (instr_valid) begin
      ctrl_p1   <= ctrl;
      result_p1 <= alu_result;
      zero_p1   <= alu_zero;
      lt_p1     <= alu_lt;
      gt_p1     <= alu_gt;
      b_cond_p1 <= b_cond_c;
    end else begin
      ctrl_p1.reg_write <= 1'b0;
      ctrl_p1.mem_read  <= 1'b0;
      ctrl_p1.mem_write <= 1'b0;
      ctrl_p1.branch    <= 1'b0;
      ctrl_p1.jump      <= 1'b0;
      ctrl_p1.illegal   <= 1'b0;
      b_cond_p1         <= 1'b0;
    end
  end

  assign reg_write  = ctrl_p1.reg_write;
  assign reg_dst    = ctrl_p1.reg_dst;
  assign mem_read   = ctrl_p1.mem_read;
  assign mem_write  = ctrl_p1.mem_write;
  assign mem_to_reg = ctrl_p1.mem_to_reg;
  assign branch     = ctrl_p1.branch;
  assign jump       = ctrl_p1.jump;
  assign alu_src    = ctrl_p1.alu_src;
  assign alu_op     = ctrl_p1.alu_op;
  assign illegal    = ctrl_p1.illegal;
  assign result     = result_p1;
  assign zero       = zero_p1;
  assign lt         = lt_p1;
  assign gt         = gt_p1;
  assign b_cond     = b_cond_p1;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Scoreboard bench for mips_decode_execute: a behavioural model predicts every
// registered output per cycle; a monitor pops and compares one cycle later.
module tb_mips_decode_execute;

  typedef struct packed {
    bit        reg_write;
    bit        reg_dst;
    bit        mem_read;
    bit        mem_write;
    bit        mem_to_reg;
    bit        branch;
    bit        jump;
    bit        alu_src;
    bit [2:0]  alu_op;
    bit [31:0] result;
    bit        zero;
    bit        lt;
    bit        gt;
    bit        b_cond;
    bit        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [15:0] imm = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        reg_write, reg_dst, mem_read, mem_write, mem_to_reg, branch, jump, alu_src;
  logic [2:0]  alu_op;
  logic [31:0] result;
  logic        zero, lt, gt, b_cond, illegal;

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  exp_t model_state = '0;

  mips_decode_execute dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .shamt(shamt), .imm(imm), .rs_data(rs_data), .rt_data(rt_data),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .alu_src(alu_src),
    .alu_op(alu_op), .result(result), .zero(zero), .lt(lt), .gt(gt),
    .b_cond(b_cond), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference: classify the instruction, then evaluate with plain arithmetic.
  function automatic exp_t model(exp_t prev, bit r, bit v, bit [5:0] op, bit [5:0] fn,
                                 bit [4:0] sh, bit [15:0] im, bit [31:0] a, bit [31:0] rt);
    exp_t      e;
    int        kind;
    bit        use_imm;
    bit        sx;
    bit [31:0] bop;
    bit [31:0] res;
    e = '0;
    if (r) return e;
    if (!v) begin
      e = prev;
      e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jump = 0; e.b_cond = 0; e.illegal = 0;
      return e;
    end
    kind = 0; use_imm = 0; sx = 0;
    case (int'(op))
      0: begin
        e.reg_write = 1; e.reg_dst = 1;
        case (int'(fn))
          32: kind = 0;
          34: kind = 1;
          36: kind = 2;
          37: kind = 3;
          42: kind = 4;
          39: kind = 5;
`ifdef MIPS_DECODE_SHIFT_EN
          0:  kind = 6;
          2:  kind = 7;
`endif
          default: kind = -1;
        endcase
      end
      8:  begin e.reg_write = 1; use_imm = 1; sx = 1; kind = 0; end
      10: begin e.reg_write = 1; use_imm = 1; sx = 1; kind = 4; end
      12: begin e.reg_write = 1; use_imm = 1; kind = 2; end
      13: begin e.reg_write = 1; use_imm = 1; kind = 3; end
      35: begin e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; use_imm = 1; sx = 1; end
      43: begin e.mem_write = 1; use_imm = 1; sx = 1; end
      4, 5: begin e.branch = 1; kind = 1; end
      2:  e.jump = 1;
      default: kind = -1;
    endcase
    if (kind < 0) begin
      e = '0;
      e.illegal = 1;
      kind = 0;
      use_imm = 0;
    end
    e.alu_src = use_imm;
    if (!use_imm)                 bop = rt;
    else if (sx && im >= 16'h8000) bop = 32'(im) + 32'hFFFF_0000;
    else                          bop = 32'(im);
    case (kind)
      0: res = a + bop;
      1: res = a - bop;
      2: res = a & bop;
      3: res = a | bop;
      4: res = ($signed(a) < $signed(bop)) ? 32'd1 : 32'd0;
      5: res = ~(a | bop);
      6: res = rt << sh;
      default: res = rt >> sh;
    endcase
    e.alu_op = 3'(kind);
    e.result = res;
    e.zero   = (res == 0);
    e.lt     = $signed(a) < $signed(bop);
    e.gt     = $signed(a) > $signed(bop);
    e.b_cond = (op == 6'd4) ? e.zero : ((op == 6'd5) ? !e.zero : 1'b0);
    return e;
  endfunction

  task automatic drive(bit r, bit v, bit [5:0] op, bit [5:0] fn, bit [4:0] sh,
                       bit [15:0] im, bit [31:0] a, bit [31:0] b);
    @(negedge clk);
    rst = r; instr_valid = v; opcode = op; funct = fn; shamt = sh;
    imm = im; rs_data = a; rt_data = b;
    model_state = model(model_state, r, v, op, fn, sh, im, a, b);
    sbq.push_back(model_state);
  endtask

  // Monitor: one expected entry per clock, checked just after the edge.
  always @(posedge clk) begin
    exp_t e;
    exp_t g;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      g.reg_write = reg_write; g.reg_dst = reg_dst; g.mem_read = mem_read;
      g.mem_write = mem_write; g.mem_to_reg = mem_to_reg; g.branch = branch;
      g.jump = jump; g.alu_src = alu_src; g.alu_op = alu_op; g.result = result;
      g.zero = zero; g.lt = lt; g.gt = gt; g.b_cond = b_cond; g.illegal = illegal;
      checks++;
      if ($isunknown({reg_write, reg_dst, mem_read, mem_write, mem_to_reg, branch, jump,
                      alu_src, alu_op, result, zero, lt, gt, b_cond, illegal}) || g !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got ctrl=%b op=%0d res=%h z/lt/gt=%b%b%b bc=%b ill=%b, required ctrl=%b op=%0d res=%h z/lt/gt=%b%b%b bc=%b ill=%b",
                 $time, {reg_write, reg_dst, mem_read, mem_write, mem_to_reg, branch, jump, alu_src},
                 alu_op, result, zero, lt, gt, b_cond, illegal,
                 {e.reg_write, e.reg_dst, e.mem_read, e.mem_write, e.mem_to_reg, e.branch, e.jump, e.alu_src},
                 e.alu_op, e.result, e.zero, e.lt, e.gt, e.b_cond, e.illegal);
      end
    end
  end

  initial begin
    bit [5:0]  ops[13] = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd0};
    bit [5:0]  fns[9]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2, 6'd0};
    bit [5:0]  op, fn;
    bit [31:0] a, b;
    int        drain;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 32, 0, 0, 5, 7);
    drive(0, 1, 6'd0, 6'd32, 0, 16'h0000, 32'd5, 32'd7);               // add -> 12
    drive(0, 0, 6'd0, 6'd32, 0, 16'h0000, 32'd1, 32'd1);               // bubble, result holds
    drive(0, 1, 6'd8, 6'd0, 0, 16'hFFFF, 32'd1, 32'd0);                // addi -> 0
    drive(0, 1, 6'd12, 6'd0, 0, 16'hFFFF, 32'hFFFF_FFFF, 32'd0);       // andi zero-extends
    drive(0, 1, 6'd4, 6'd0, 0, 16'h0000, 32'd9, 32'd9);                // beq taken
    drive(0, 1, 6'd5, 6'd0, 0, 16'h0000, 32'd9, 32'd9);                // bne not taken
    drive(0, 1, 6'd5, 6'd0, 0, 16'h0000, 32'd9, 32'd3);                // bne taken, gt
    drive(0, 1, 6'd35, 6'd0, 0, 16'hFFFC, 32'h100, 32'd0);             // lw -> 0xFC
    drive(0, 1, 6'd43, 6'd0, 0, 16'h0010, 32'h100, 32'd55);            // sw
    drive(0, 1, 6'd0, 6'd0, 5'd31, 16'h0000, 32'd77, 32'd1);           // sll 31
    drive(0, 1, 6'd0, 6'd2, 5'd4, 16'h0000, 32'd0, 32'h8000_0000);     // srl 4
    drive(0, 1, 6'd10, 6'd0, 0, 16'h8000, 32'h8000_0000, 32'd0);       // slti negative
    drive(0, 1, 6'd13, 6'd0, 0, 16'h8001, 32'h0000_0F00, 32'd0);       // ori
    drive(0, 1, 6'd0, 6'd42, 0, 16'h0000, 32'hFFFF_FFFF, 32'd0);       // slt -1 < 0
    drive(0, 1, 6'd0, 6'd39, 0, 16'h0000, 32'h0F0F_0000, 32'h0000_00F0); // nor
    drive(0, 1, 6'd63, 6'd0, 0, 16'h0000, 32'd3, 32'd4);               // illegal opcode
    drive(0, 1, 6'd0, 6'd63, 0, 16'h0000, 32'd3, 32'd4);               // illegal funct
    drive(0, 1, 6'd2, 6'd0, 0, 16'h1234, 32'd2, 32'd2);                // j
    drive(0, 1, 6'd0, 6'd34, 0, 16'h0000, 32'd0, 32'd1);               // sub wraps
    drive(1, 1, 6'd0, 6'd32, 0, 16'h0000, 32'd5, 32'd7);               // reset mid-stream
    drive(0, 1, 6'd0, 6'd32, 0, 16'h0000, 32'hFFFF_FFFF, 32'd1);       // add wraps to 0

    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
        default: ;
      endcase
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 99) < 85, op, fn,
            5'($urandom), 16'($urandom), a, b);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drain = 0;
    while (sbq.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
